// File: rtl/nibble_serial_add_ctrl.sv
// Sequences a WIDTH-bit add through an external combinational 4-bit adder,
// one nibble per cycle LSB first, chaining carry between cycles.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic [3:0]       x,
  output logic [3:0]       y,
  output logic             z,
  input  logic [3:0]       s,
  input  logic             c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic              carry_q, carry_d, cout_q, cout_d;
  logic [IDXW-1:0]   idx_q, idx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    x         = 4'h0;
    y         = 4'h0;
    z         = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // adder result s/c is combinational from x/y/z, so it is captured this same cycle
        x = a_q[4*idx_q +: 4];
        y = b_q[4*idx_q +: 4];
        z = carry_q;
        sum_d[4*idx_q +: 4] = s;
        carry_d = c;
        if (idx_q == LAST) begin
          cout_d  = c;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Randomized + directed bench for nibble_serial_add_ctrl (WIDTH=16) against a+b+cin.
module tb_nibble_serial_add_ctrl;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0, in_ready;
  logic [WIDTH-1:0] a_in = '0, b_in = '0;
  logic             cin = 1'b0;
  logic [3:0]       x, y, s;
  logic             z, c;
  logic             out_valid, out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int n_chk  = 0;
  int n_pass = 0;

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .cin(cin), .x(x), .y(y), .z(z), .s(s), .c(c),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
  );

  // the 4-bit ripple adder stage
  assign {c, s} = 5'(x) + 5'(y) + 5'(z);

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // carry entering nibble i of a+b+ci
  function automatic logic carry_into(input logic [WIDTH-1:0] a, b, input logic ci, input int i);
    longint mask, t;
    mask = (64'd1 << (4*i)) - 1;
    t = (longint'(a) & mask) + (longint'(b) & mask) + longint'(ci);
    return 1'(t >> (4*i));
  endfunction

  // One full transaction. early: out_ready high from accept on; else stall cycles in DONE.
  // hold: keep in_valid up with the next operands during RUN/DONE.
  task automatic run_op(input logic [WIDTH-1:0] a, b, input logic ci, input int stall,
                        input bit early, input bit hold,
                        input logic [WIDTH-1:0] na, nb, input logic nci);
    logic [WIDTH:0] exp;
    exp = (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(ci);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; a_in = a; b_in = b; cin = ci;
    out_ready = early;
    tick();
    if (hold) begin a_in = na; b_in = nb; cin = nci; end
    else begin in_valid = 1'b0; a_in = $urandom; b_in = $urandom; cin = 1'($urandom); end
    for (int i = 0; i < NIB; i++) begin
      chk("run_in_ready", in_ready, 0);
      chk("run_out_valid", out_valid, 0);
      chk("x", x, 32'((a >> (4*i)) & 'hF));
      chk("y", y, 32'((b >> (4*i)) & 'hF));
      chk("z", z, carry_into(a, b, ci, i));
      tick();
    end
    chk("out_valid", out_valid, 1);
    chk("done_in_ready", in_ready, 0);
    chk("sum", sum, 32'(exp[WIDTH-1:0]));
    chk("cout", cout, exp[WIDTH]);
    chk("done_xyz", {x, y, z}, 0);
    if (!early) begin
      for (int k = 0; k < stall; k++) begin
        tick();
        chk("stall_valid", out_valid, 1);
        chk("stall_in_ready", in_ready, 0);
        chk("stall_sum", sum, 32'(exp[WIDTH-1:0]));
        chk("stall_cout", cout, exp[WIDTH]);
      end
      out_ready = 1'b1;
    end
    tick();
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic             rc;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_xyz", {x, y, z}, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", in_ready, 1);

    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("ffff_sum", sum, 32'h0000);
    chk("ffff_cout", cout, 1);
    run_op(16'h1234, 16'h4321, 1'b1, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("1234_sum", sum, 32'h5556);
    chk("1234_cout", cout, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 5, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("bp_cout", cout, 1);
    // new operands held during RUN are taken only after the DONE handshake
    run_op(16'h00FF, 16'h0F0F, 1'b0, 1, 1'b0, 1'b1, 16'h7777, 16'h2222, 1'b1);
    run_op(16'h7777, 16'h2222, 1'b1, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("hold_sum", sum, 32'h999A);
    run_op(16'h0F00, 16'h0100, 1'b1, 0, 1'b1, 1'b0, '0, '0, 1'b0);

    // reset mid-RUN at idx=2
    in_valid = 1'b1; a_in = 16'hABCD; b_in = 16'h1111; cin = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_x", x, 32'hB);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_xyz", {x, y, z}, 0);
    #2 rst = 1'b0;
    tick();
    run_op(16'h0005, 16'h0003, 1'b0, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("after_rst_sum", sum, 32'h0008);

    for (int n = 0; n < 1000; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        tick();
        chk("gap_ready", in_ready, 1);
        chk("gap_valid", out_valid, 0);
      end
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      if (n % 16 == 0) ra = 16'hFFFF;
      run_op(ra, rb, rc, $urandom_range(0, 3), ($urandom_range(0, 3) == 0), 1'b0, '0, '0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
